// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with a per-register busy scoreboard.
// Optional hard-wired zero register and same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       we0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd0,
    input  logic [DATA_W-1:0]          wd1,
    input  logic                       busy_set,
    input  logic [ADDR_W-1:0]          busy_addr,
    output logic [(1<<ADDR_W)-1:0]     busy_vec
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic              w_wr0;
    logic              w_wr1;
    logic              w_set;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [ADDR_W-1:0] w_ra;

    // Writes/sets aimed at the zero register are dropped before they reach storage.
    assign w_wr0 = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign w_wr1 = we1 && !((ZERO_REG != 0) && (wa1 == '0));
    assign w_set = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));

    always_comb begin
        w_busy_nxt = r_busy;
        if (we0) w_busy_nxt[wa0] = 1'b0;
        if (we1) w_busy_nxt[wa1] = 1'b0;
        if (w_set) w_busy_nxt[busy_addr] = 1'b1;
    end

    // Port 1 is written last so it wins an address collision with port 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr0) r_mem[wa0] <= wd0;
            if (w_wr1) r_mem[wa1] <= wd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        w_ra    = '0;
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                w_ra = rd_addr[i*ADDR_W +: ADDR_W];
                rd_data[i*DATA_W +: DATA_W] = r_mem[w_ra];
                rd_busy[i] = r_busy[w_ra];
                if (BYPASS != 0) begin
                    if (w_wr0 && (wa0 == w_ra)) rd_data[i*DATA_W +: DATA_W] = wd0;
                    if (w_wr1 && (wa1 == w_ra)) rd_data[i*DATA_W +: DATA_W] = wd1;
                    if ((we0 && (wa0 == w_ra)) || (we1 && (wa1 == w_ra))) rd_busy[i] = 1'b0;
                end
                if ((ZERO_REG != 0) && (w_ra == '0)) rd_data[i*DATA_W +: DATA_W] = '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypassing and non-bypassing instances share one stimulus
// stream against an array model; a 4-port 16-bit instance checks slice packing.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [9:0]  rd_addr;
    logic [63:0] a_rd_data, b_rd_data;
    logic [1:0]  a_rd_busy, b_rd_busy;
    logic [31:0] a_busy_vec, b_busy_vec;
    logic        we0, we1, busy_set;
    logic [4:0]  wa0, wa1, busy_addr;
    logic [31:0] wd0, wd1;

    logic [11:0] c_rd_addr;
    logic [63:0] c_rd_data;
    logic [3:0]  c_rd_busy;
    logic        c_we0, c_we1, c_busy_set;
    logic [2:0]  c_wa0, c_wa1, c_busy_addr;
    logic [15:0] c_wd0, c_wd1;
    logic [7:0]  c_busy_vec;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy_vec(a_busy_vec));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy_vec(b_busy_vec));

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) u_c (
        .clk(clk), .reset(reset), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .we0(c_we0), .we1(c_we1), .wa0(c_wa0), .wa1(c_wa1), .wd0(c_wd0), .wd1(c_wd1),
        .busy_set(c_busy_set), .busy_addr(c_busy_addr), .busy_vec(c_busy_vec));

    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_busy = '0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (reset || a == 0) return 32'd0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (reset) return 1'b0;
        if (byp && ((we0 && wa0 == a) || (we1 && wa1 == a))) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic settle_check(input string tag);
        logic [4:0] a;
        #3;
        for (int p = 0; p < 2; p++) begin
            a = rd_addr[p*5 +: 5];
            check($sformatf("%s rdA%0d", tag, p), a_rd_data[p*32 +: 32], exp_rd(a, 1'b1));
            check($sformatf("%s rdB%0d", tag, p), b_rd_data[p*32 +: 32], exp_rd(a, 1'b0));
            check($sformatf("%s busyA%0d", tag, p), a_rd_busy[p], exp_busy(a, 1'b1));
            check($sformatf("%s busyB%0d", tag, p), b_rd_busy[p], exp_busy(a, 1'b0));
        end
        check($sformatf("%s vecA", tag), a_busy_vec, reset ? 32'd0 : m_busy);
        check($sformatf("%s vecB", tag), b_busy_vec, reset ? 32'd0 : m_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
            if (we0) m_busy[wa0] = 1'b0;
            if (we1) m_busy[wa1] = 1'b0;
            if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; busy_set = 0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; busy_addr = '0;
    endtask

    initial begin
        logic [15:0] exp_c [4];
        exp_c = '{16'd4, 16'd2, 16'd1, 16'd3};
        reset = 1'b1;
        idle();
        rd_addr = '0;
        c_rd_addr = '0; c_we0 = 0; c_we1 = 0; c_busy_set = 0;
        c_wa0 = '0; c_wa1 = '0; c_wd0 = '0; c_wd1 = '0; c_busy_addr = '0;
        model_reset();
        @(posedge clk); #1;

        // Writes and busy_set presented during reset must be dropped.
        we0 = 1; wa0 = 5'd4; wd0 = 32'h1234; busy_set = 1; busy_addr = 5'd4;
        rd_addr[0 +: 5] = 5'd4;
        settle_check("in_reset");
        check("reset_rd0", a_rd_data[31:0], 32'd0);
        tick();
        reset = 1'b0;
        idle();
        settle_check("post_reset");
        check("rst_nowrite", a_rd_data[31:0], 32'd0);
        check("rst_novec", a_busy_vec, 32'd0);
        tick();

        // Dual write to the same address: port 1 wins, also in the bypass path.
        we0 = 1; we1 = 1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'h11; wd1 = 32'h22;
        rd_addr[5 +: 5] = 5'd7;
        settle_check("collide");
        check("collide_byp", a_rd_data[63:32], 32'h22);
        tick();
        idle();
        rd_addr[0 +: 5] = 5'd7;
        settle_check("collide_next");
        check("collide_rdA", a_rd_data[31:0], 32'h22);
        check("collide_rdB", b_rd_data[31:0], 32'h22);
        tick();

        we0 = 1; wa0 = 5'd3; wd0 = 32'hA5A5;
        rd_addr[0 +: 5] = 5'd3;
        settle_check("bypass");
        check("bypass_on", a_rd_data[31:0], 32'hA5A5);
        check("bypass_off", b_rd_data[31:0], 32'd0);
        tick();
        idle();
        settle_check("bypass_next");
        check("bypass_off_next", b_rd_data[31:0], 32'hA5A5);
        tick();

        we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF; busy_set = 1; busy_addr = 5'd0;
        rd_addr[0 +: 5] = 5'd0;
        settle_check("zero_wr");
        tick();
        idle();
        settle_check("zero_rd");
        check("zero_rd0", a_rd_data[31:0], 32'd0);
        check("zero_vec0", a_busy_vec[0], 1'b0);
        tick();

        busy_set = 1; busy_addr = 5'd9;
        rd_addr[0 +: 5] = 5'd9;
        settle_check("sb_set");
        tick();
        we0 = 1; wa0 = 5'd9; wd0 = 32'h99;
        settle_check("sb_both");
        tick();
        check("sb_set_wins", a_busy_vec[9], 1'b1);
        idle();
        we0 = 1; wa0 = 5'd9; wd0 = 32'h9A;
        settle_check("sb_clr");
        tick();
        check("sb_cleared", a_busy_vec[9], 1'b0);
        idle();

        // Asynchronous reset asserted between edges must clear reads at once.
        we0 = 1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
        settle_check("r5_wr");
        tick();
        idle();
        rd_addr[0 +: 5] = 5'd5;
        settle_check("r5_rd");
        check("r5_before", a_rd_data[31:0], 32'hDEAD_BEEF);
        reset = 1'b1;
        model_reset();
        #1;
        check("r5_in_reset", a_rd_data[31:0], 32'd0);
        check("vec_in_reset", a_busy_vec, 32'd0);
        tick();
        reset = 1'b0;
        settle_check("r5_after");
        check("r5_after_rst", a_rd_data[31:0], 32'd0);
        tick();

        c_we0 = 1; c_wa0 = 3'd1; c_wd0 = 16'd1; c_we1 = 1; c_wa1 = 3'd2; c_wd1 = 16'd2;
        tick();
        c_wa0 = 3'd3; c_wd0 = 16'd3; c_wa1 = 3'd4; c_wd1 = 16'd4;
        tick();
        c_we0 = 0; c_we1 = 0;
        c_rd_addr = {3'd3, 3'd1, 3'd2, 3'd4};
        #3;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("param_rd%0d", p), c_rd_data[p*16 +: 16], exp_c[p]);
        end
        check("param_busy", c_rd_busy, 4'd0);
        tick();

        repeat (400) begin
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            wa0 = 5'($urandom_range(0, 11));
            wa1 = 5'($urandom_range(0, 11));
            wd0 = $urandom;
            wd1 = $urandom;
            busy_set  = 1'($urandom_range(0, 1));
            busy_addr = 5'($urandom_range(0, 11));
            rd_addr = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
            settle_check("rand");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; depth = 2^ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2: number of read ports (1..8).
REQ-004 SHALL have parameter ZERO_REG, default 1: 1 makes register 0 read-only zero.
REQ-005 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding.
REQ-006 SHALL have port clk, input, 1, single clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port rd_addr, input, NUM_RD*ADDR_W, packed read addresses; port i at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rd_data, output, NUM_RD*DATA_W, packed read data; port i at [i*DATA_W +: DATA_W].
REQ-010 SHALL have port rd_busy, output, NUM_RD, scoreboard busy bit of each read address.
REQ-011 SHALL have ports we0/we1, input, 1 each, write enables.
REQ-012 SHALL have ports wa0/wa1, input, ADDR_W each, write addresses.
REQ-013 SHALL have ports wd0/wd1, input, DATA_W each, write data.
REQ-014 SHALL have port busy_set, input, 1, marks busy_addr as pending a write.
REQ-015 SHALL have port busy_addr, input, ADDR_W, register to mark busy.
REQ-016 SHALL have port busy_vec, output, 2^ADDR_W, registered scoreboard state.

Function
REQ-017 SHALL update storage on the rising clk edge for each port with weN=1, storing wdN at waN.
REQ-018 SHALL let write port 1 win when we0=we1=1 and wa0=wa1; wd0 is discarded.
REQ-019 SHALL ignore writes to address 0 when ZERO_REG=1; rd_data for address 0 SHALL always be 0.
REQ-020 SHALL read combinationally: rd_data[i] = storage[rd_addr[i]] in the same cycle.
REQ-021 SHALL forward when BYPASS=1 and weN=1 with waN=rd_addr[i]: rd_data[i]=wdN, with port 1 winning over port 0; no forwarding to address 0 when ZERO_REG=1.
REQ-022 SHALL return pre-write storage contents on same-cycle read/write collisions when BYPASS=0.
REQ-023 SHALL set busy_vec[busy_addr] at the clock edge when busy_set=1.
REQ-024 SHALL clear busy_vec[waN] at the clock edge when weN=1.
REQ-025 SHALL give set priority over clear when busy_set and a write target the same address in the same cycle, so the bit ends at 1.
REQ-026 SHALL never set busy_vec[0] when ZERO_REG=1.
REQ-027 SHALL drive rd_busy[i] = busy_vec[rd_addr[i]], with writes in the current cycle clearing it combinationally when BYPASS=1.
REQ-028 SHALL have unlimited write throughput: writes take one cycle, and data is visible to reads in the next cycle, or in the same cycle via bypass.

Reset
REQ-029 SHALL asynchronously clear all storage to 0 and busy_vec to 0 while reset=1, independent of clk.
REQ-030 SHALL ignore writes and busy_set while reset=1; an edge coincident with reset deassertion SHALL NOT write.
REQ-031 SHALL drive rd_data to 0 and rd_busy to 0 for all ports while reset=1.

Verification
REQ-032 SHALL verify reset mid-run: write r5=0xDEADBEEF, assert reset between edges -> rd_data=0 immediately; after release, reading r5 gives 0.
REQ-033 SHALL verify dual-write collision: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> r7 reads 0x22 next cycle.
REQ-034 SHALL verify bypass: BYPASS=1, we0=1, wa0=3, wd0=0xA5A5, rd_addr[0]=3 in the same cycle -> rd_data[0]=0xA5A5; with BYPASS=0 -> old value 0.
REQ-035 SHALL verify the zero register: we1=1, wa1=0, wd1=0xFFFFFFFF, busy_set=1 on address 0 -> r0 reads 0 and busy_vec[0]=0.
REQ-036 SHALL verify scoreboard set-beats-clear: busy_set on r9, then next cycle we0 to r9 with busy_set=1 on r9 -> busy_vec[9]=1; next cycle we0 to r9 only -> busy_vec[9]=0.
REQ-037 SHALL verify parametrisation: NUM_RD=4, DATA_W=16, ADDR_W=3, four distinct reads of pre-written values 1..4 -> each rd_data slice returns the correct value.
